spi_config_loader: RTL
======================

# spi_config_loader

SPI master that writes a configuration word into the FM transmitter's SPI configuration shift register and optionally reads it back to verify it. On a start request, or automatically after reset, it latches a W-bit word and shifts it out MSB-first in SPI mode 0. In verify mode it runs a second identical pass, compares the bits returned on MISO against the latched word, and flags any mismatch. It sits between the on-chip control logic (or a test harness) and the SPI pins of the configuration register.

## Interface
Parameters:
- W, 42: configuration word width; must equal the target register length (N+L+D+3+3+1 for defaults).
- DIV, 4: system clocks per SPI half-period, ≥1.
- VERIFY, 1: 1 = write pass followed by a readback/compare pass; 0 = write pass only.
- AUTO_START, 0: 1 = start a load with the `cfg_word` present on the first cycle after reset release.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request, sampled only in IDLE.
- cfg_word  in  W  word to load, latched in the cycle start is accepted.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  sticky verify mismatch; cleared when the next start is accepted.
- spi_clk  out  1  SPI clock, idles low.
- spi_csn  out  1  chip select, active low, idles high.
- spi_mosi  out  1  serial data to target, MSB first.
- spi_miso  in  1  serial data from target (target's register MSB).

## Operation
- All outputs are registered. Reset values: spi_csn=1, spi_clk=0, spi_mosi=0, busy=0, done=0, error=0, state=IDLE.
- States:
  - IDLE: waits for start.
  - LOW: spi_clk=0; mosi = current bit.
  - HIGH: spi_clk=1.
  - TAIL: spi_clk=0, csn still low.
  - GAP: csn=1.
- IDLE→LOW: on start=1 (or the first post-reset cycle if AUTO_START=1). Latch cfg_word, set bit index to W-1, pass=0, clear error, busy=1, csn=0, mosi=cfg_word[W-1].
- LOW lasts DIV cycles, then →HIGH. On the edge that raises spi_clk, register spi_miso into the sample bit (this is the target's value before its shift).
- HIGH lasts DIV cycles. Then:
  - if index>0: index decrements and state →LOW, with mosi = next bit;
  - if index=0: state →TAIL.
- TAIL lasts DIV cycles, then →GAP with csn=1 and mosi=0.
- GAP lasts DIV cycles. Then:
  - if VERIFY=1 and pass=0: pass=1, index=W-1, state →LOW with csn=0;
  - otherwise: state →IDLE, busy=0, done=1 for one cycle.
- Verify pass (pass=1) shifts the identical word again, so the target's contents are unchanged on success. Each sampled bit is compared with latched[index]; any mismatch sets error, which stays set until the next accepted start.
- Pass 0 samples are ignored.
- start while busy is ignored, with no queuing. If start is held high, the next load begins in the cycle after done.
- cfg_word changes after acceptance have no effect.
- rst_n low at any time forces reset values asynchronously, with no done pulse; a partially shifted word remains in the target. After release with AUTO_START=0, the block stays in IDLE.
- Bit counter width is clog2(W); divider counter width is clog2(DIV)+1. The divider reloads on every state change.

## Timing
- Per pass:
  - csn low for (2W+1)·DIV cycles;
  - W rising edges of spi_clk;
  - GAP of DIV cycles;
  - total (2W+2)·DIV cycles.
- start accepted at the edge of cycle t: csn falls in cycle t+1.
- busy is high for P·(2W+2)·DIV cycles, where P = 1+VERIFY.
- done is high in cycle t+1+P·(2W+2)·DIV, with busy already 0.
- mosi changes only on the cycle spi_clk is low (start of LOW). It is stable for DIV cycles before the rising edge and DIV cycles after it.
- error is valid by the done cycle.

## Test plan
- Single write (W=8, DIV=2, VERIFY=0), cfg_word=0xA5, start at t:
  - mosi at the 8 rising edges is 1,0,1,0,0,1,0,1;
  - csn low for 34 cycles;
  - done at t+37;
  - target model holds 0xA5.
- Verify with loopback target model (W=8, DIV=2, VERIFY=1), cfg=0x3C:
  - 16 rising edges total;
  - done at t+73;
  - error=0;
  - target holds 0x3C.
- Faulty MISO (miso tied 0), cfg=0x81, VERIFY=1:
  - error=1 at done;
  - a following start with a good target clears error at acceptance and ends with error=0.
- Start pulses during busy are ignored, with no extra edges. With start held high:
  - the second csn fall occurs in the cycle after done;
  - two complete loads are performed.
- Reset mid-operation, asserted during bit index 4:
  - same cycle: csn=1, spi_clk=0, busy=0, no done;
  - with AUTO_START=1, csn falls one cycle after rst_n release and the load completes normally.
- DIV=1 boundary (W=8, VERIFY=0):
  - spi_clk toggles every cycle;
  - 8 rising edges;
  - busy for 18 cycles;
  - cfg=0xFF then cfg=0x00 loaded correctly.

Source files
------------

// File: rtl/spi_config_loader.sv
// rtl/spi_config_loader.sv - SPI mode-0 master that loads and optionally verifies a configuration word
module spi_config_loader #(
    parameter int W          = 42,
    parameter int DIV        = 4,
    parameter bit VERIFY     = 1'b1,
    parameter bit AUTO_START = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] cfg_word,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         spi_clk,
    output logic         spi_csn,
    output logic         spi_mosi,
    input  logic         spi_miso
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int DW = $clog2(DIV) + 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);
    localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, TAIL, GAP} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] idx_dec;
    logic [W-1:0]  word_q, word_d;
    logic          pass_q, pass_d;
    logic          auto_q, auto_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          sclk_q, sclk_d;
    logic          csn_q, csn_d;
    logic          mosi_q, mosi_d;
    logic          div_end;

    assign div_end = (div_q == '0);
    assign idx_dec = idx_q - IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= DIV_TOP;
            idx_q   <= IDX_TOP;
            word_q  <= '0;
            pass_q  <= 1'b0;
            auto_q  <= AUTO_START;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            pass_q  <= pass_d;
            auto_q  <= auto_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_end ? DIV_TOP : div_q - DW'(1);
        idx_d   = idx_q;
        word_d  = word_q;
        pass_d  = pass_q;
        auto_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        sclk_d  = sclk_q;
        csn_d   = csn_q;
        mosi_d  = mosi_q;

        case (state_q)
            IDLE: begin
                div_d = DIV_TOP;
                // auto_q is only ever high in the first cycle after reset release
                if (start || auto_q) begin
                    state_d = LOW;
                    word_d  = cfg_word;
                    idx_d   = IDX_TOP;
                    pass_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    csn_d   = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = cfg_word[W-1];
                end
            end
            LOW: begin
                if (div_end) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    // miso here is the target's bit before it shifts on this rising edge
                    if (pass_q && (spi_miso != word_q[idx_q])) begin
                        error_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (div_end) begin
                    sclk_d = 1'b0;
                    if (idx_q != '0) begin
                        idx_d   = idx_dec;
                        mosi_d  = word_q[idx_dec];
                        state_d = LOW;
                    end else begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (div_end) begin
                    state_d = GAP;
                    csn_d   = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            GAP: begin
                if (div_end) begin
                    if (VERIFY && !pass_q) begin
                        pass_d  = 1'b1;
                        idx_d   = IDX_TOP;
                        state_d = LOW;
                        csn_d   = 1'b0;
                        mosi_d  = word_q[W-1];
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign spi_clk  = sclk_q;
    assign spi_csn  = csn_q;
    assign spi_mosi = mosi_q;
endmodule
